pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 16-bit combinational adder.
- Adds or subtracts two W-bit operands CHUNK bits per stage, with carry rippled between pipeline registers.
- Valid/ready handshakes on both sides with full backpressure; one result per cycle at steady state.
- Sits between operand sources and result consumers in the datapath labs; the existing file-driven checker style applies to its results.

---
 rtl/pipe_adder_pkg.sv | 38 +++
 rtl/cla_slice.sv | 46 ++++
 rtl/pipe_adder.sv | 111 +++++++++++
 tb/tb_pipe_adder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder_pkg
// Description : Shared types and helpers for the pipelined chunked adder.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_adder_pkg;

    // Widest operand a stage register can carry.
    localparam int c_MAX_W = 64;

    // Stage register: result chunks built so far, operands still to be
    // consumed (b already inverted in subtract mode), inter-stage carry.
    typedef struct packed {
        logic               valid;
        logic               sub;
        logic               sat;
        logic               carry;
        logic               ovf;
        logic [c_MAX_W-1:0] a;
        logic [c_MAX_W-1:0] b;
        logic [c_MAX_W-1:0] y;
    } stage_t;

    function automatic int nstage(input int w, input int chunk);
        return w / chunk;
    endfunction

    function automatic logic [c_MAX_W-1:0] sat_pos(input int w);
        return (c_MAX_W'(1) << (w - 1)) - c_MAX_W'(1);
    endfunction

    function automatic logic [c_MAX_W-1:0] sat_neg(input int w);
        return c_MAX_W'(1) << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice
// Description : Combinational CHUNK-bit carry-lookahead adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;
    logic             w_acc;
    logic             w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of products of g/p/ci, not a ripple chain.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_pp   = 1'b0;
        w_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            w_acc = w_g[i];
            w_pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & w_g[j]);
                w_pp  = w_pp & w_p[j];
            end
            w_c[i+1] = w_acc | (w_pp & ci);
        end
    end

    assign s  = w_p ^ w_c[CHUNK-1:0];
    assign co = w_c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder
// Description : W-bit add/sub, CHUNK bits per pipeline stage, valid/ready on
//               both sides. PIPE_ADDER_SAT_EN adds a per-beat saturate input.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
`ifdef PIPE_ADDER_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         ovf
);
    localparam int c_NSTAGE = nstage(W, CHUNK);

    logic   w_adv;
    stage_t w_tail;
    logic   w_unused_tail;

    if ((W % CHUNK) != 0 || W > c_MAX_W) begin : g_bad_cfg
        $error("pipe_adder: W must be a multiple of CHUNK and at most %0d", c_MAX_W);
    end

    // The pipe moves as one unit, so bubbles keep their slots under stall.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < c_NSTAGE; k++) begin : g_stage
        stage_t           w_in;
        stage_t           w_next;
        stage_t           r_q;
        logic [CHUNK-1:0] w_sum;
        logic             w_co;

        if (k == 0) begin : g_head
            always_comb begin
                w_in       = '0;
                w_in.valid = in_valid;
                w_in.sub   = sub;
`ifdef PIPE_ADDER_SAT_EN
                w_in.sat   = sat;
`endif
                w_in.carry = sub | cin;
                w_in.a     = c_MAX_W'(a);
                w_in.b     = c_MAX_W'(sub ? ~b : b);
            end
        end else begin : g_link
            assign w_in = g_stage[k-1].r_q;
        end

        cla_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a  (w_in.a[k*CHUNK +: CHUNK]),
            .b  (w_in.b[k*CHUNK +: CHUNK]),
            .ci (w_in.carry),
            .s  (w_sum),
            .co (w_co)
        );

        always_comb begin
            w_next                     = w_in;
            w_next.y[k*CHUNK +: CHUNK] = w_sum;
            w_next.carry               = w_co;
            if (k == c_NSTAGE - 1) begin
                w_next.ovf = (w_in.a[W-1] == w_in.b[W-1]) && (w_sum[CHUNK-1] != w_in.a[W-1]);
`ifdef PIPE_ADDER_SAT_EN
                if (w_in.sat && w_next.ovf) begin
                    w_next.y = w_in.a[W-1] ? sat_neg(W) : sat_pos(W);
                end
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_adv) begin
                r_q <= w_next;
            end
        end
    end

    assign w_tail    = g_stage[c_NSTAGE-1].r_q;
    assign out_valid = w_tail.valid;
    assign y         = w_tail.y[W-1:0];
    assign cout      = w_tail.carry;
    assign ovf       = w_tail.ovf;

    // Operand and spare result bits are dead once the last stage is loaded.
    assign w_unused_tail = ^w_tail;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_adder
// Description : Directed self-checking bench for pipe_adder (W=16, CHUNK=4),
//               with a queue-based arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    typedef struct {
        logic [15:0] y;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        cout;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    res_t        exp_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_y     = '0;
    logic        prev_cout  = 1'b0;
    logic        prev_ovf   = 1'b0;

    always #5 clk = ~clk;

    pipe_adder #(
        .W     (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPE_ADDER_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: true signed/unsigned arithmetic, then reduce modulo 2^16.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub, input logic msat);
        res_t r;
        int   sa;
        int   sb;
        int   s;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            s      = sa - sb;
            r.cout = (ma >= mb);
        end else begin
            s      = sa + sb + int'(mcin);
            r.cout = (int'(ma) + int'(mb) + int'(mcin)) > 65535;
        end
        r.ovf = (s > 32767) || (s < -32768);
        r.y   = s[15:0];
        if (msat && r.ovf) r.y = (s > 0) ? 16'h7FFF : 16'h8000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        res_t e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (prev_stall) begin
                chk("hold_y", {16'b0, y}, {16'b0, prev_y});
                chk("hold_cout", {31'b0, cout}, {31'b0, prev_cout});
                chk("hold_ovf", {31'b0, ovf}, {31'b0, prev_ovf});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got y=%0h with no beat outstanding", y);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_y", {16'b0, y}, {16'b0, e.y});
                    chk("out_cout", {31'b0, cout}, {31'b0, e.cout});
                    chk("out_ovf", {31'b0, ovf}, {31'b0, e.ovf});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, sat));
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_cout  = cout;
            prev_ovf   = ovf;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat is taken.
    task automatic put_beat(input logic [15:0] pa, input logic [15:0] pb, input logic pcin,
                            input logic psub, input logic psat, output int waits);
        in_valid = 1'b1;
        a        = pa;
        b        = pb;
        cin      = pcin;
        sub      = psub;
        sat      = psat;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: got in_ready=0 for %0d cycles expected 1", waits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        sat      = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [15:0] ey, input logic ec, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!(out_valid && out_ready)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no result after %0d cycles expected one", name, n);
        end else begin
            chk({name, "_y"}, {16'b0, y}, {16'b0, ey});
            chk({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
            chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin : main
        int waits;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        sat       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_y", {16'b0, y}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Positive overflow, latency of exactly four cycles.
        put_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, waits);
        idle();
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("latency", n, 32'd3);
        chk("t1_y", {16'b0, y}, 32'h8000);
        chk("t1_cout", {31'b0, cout}, 32'd0);
        chk("t1_ovf", {31'b0, ovf}, 32'd1);
        @(posedge clk);
        #1;

        // Subtraction with borrow, then negative-minus-positive overflow.
        put_beat(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, waits);
        idle();
        wait_out("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        put_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, waits);
        idle();
        wait_out("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream, no gaps.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    put_beat(16'(i), 16'(i), 1'b1, 1'b0, 1'b0, waits);
                    chk("b2b_in_ready_waits", waits, 32'd0);
                end
                idle();
            end
            begin
                int m;
                m = 0;
                @(negedge clk);
                while (!out_valid && m < 20) begin
                    m++;
                    @(negedge clk);
                end
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
                    chk("b2b_y", {16'b0, y}, 32'(2 * i + 1));
                end
            end
        join
        @(posedge clk);
        #1;

        // Six-cycle output stall in the middle of a stream.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    put_beat(16'(100 + i), 16'(3 * i), (i % 2) == 1, (i % 3) == 2, 1'b0, waits);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        repeat (10) @(negedge clk);
        chk("drain_bp", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            put_beat(16'(i + 1), 16'(i + 1), 1'b0, 1'b0, 1'b0, waits);
        end
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_flush_in_ready", {31'b0, in_ready}, 32'd1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("rst_no_stale", n, 32'd0);
        @(posedge clk);
        #1;
        put_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, waits);
        idle();
        wait_out("post_rst", 16'h0000, 1'b1, 1'b0);

`ifdef PIPE_ADDER_SAT_EN
        put_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, waits);
        idle();
        wait_out("sat_pos", 16'h7FFF, 1'b0, 1'b1);
        put_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, waits);
        idle();
        wait_out("sat_neg", 16'h8000, 1'b1, 1'b1);
`endif

        repeat (6) @(negedge clk);
        chk("final_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
